memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the maximum WAIT cycles without ack before a bus access is aborted.
REQ-002 ms_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 ms_rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-004 ms_i_ce  in  1  SHALL mark a valid instruction from the execute stage.
REQ-005 ms_i_alu_value  in  `DWIDTH  SHALL carry the ALU result: effective address for loads/stores, result otherwise.
REQ-006 ms_i_data_rt  in  `DWIDTH  SHALL carry store data.
REQ-007 ms_i_opcode  in  `OPCODE_WIDTH  SHALL carry the instruction opcode.
REQ-008 ms_i_rd_addr  in  5 and ms_i_regwrite  in  1  SHALL carry the writeback target and enable.
REQ-009 ms_o_stall  out  1  SHALL tell upstream to hold its outputs.
REQ-010 Bus outputs: ms_o_mem_req 1, ms_o_mem_we 1, ms_o_mem_addr `DWIDTH (word-aligned, addr[1:0]=0), ms_o_mem_wdata `DWIDTH, ms_o_mem_sel 4.
REQ-011 Bus inputs: ms_i_mem_ack 1, ms_i_mem_rdata `DWIDTH.
REQ-012 Results: ms_o_ce 1, ms_o_data `DWIDTH, ms_o_rd_addr 5, ms_o_regwrite 1, ms_o_misalign 1, ms_o_bus_err 1.

Function
REQ-013 Memory ops: LB, LH, LW, LBU, LHU, SB, SH, SW; all other opcodes are pass-through.
REQ-014 Pass-through, accepted in IDLE: next edge drives ms_o_ce=1, ms_o_data=ms_i_alu_value, rd_addr/regwrite copied; latency 1 cycle.
REQ-015 FSM states IDLE, WAIT; reset state IDLE.
REQ-016 IDLE + ms_i_ce + aligned memory op: next edge -> WAIT; req=1; addr/we/wdata/sel registered.
REQ-017 Alignment: byte always aligned; half requires addr[0]=0; word requires addr[1:0]=0.
REQ-018 Misaligned memory op: no request; next edge ms_o_ce=1, ms_o_regwrite=0, ms_o_misalign=1; stay IDLE.
REQ-019 Byte lanes little-endian: sel = 0001<<a (byte), 0011<<a (half), 1111 (word); a=addr[1:0].
REQ-020 Store wdata: byte replicated 4x, half replicated 2x, word unchanged.
REQ-021 Load data: rdata >> (8*a), low 8/16 bits sign-extended (LB, LH) or zero-extended (LBU, LHU); LW unmodified.
REQ-022 ms_o_stall SHALL equal (state==WAIT), combinationally.
REQ-023 In WAIT, req/addr/we/wdata/sel SHALL stay stable until ack sampled high.
REQ-024 WAIT + ack: next edge req=0, ms_o_ce=1, state IDLE; load -> ms_o_data extracted and regwrite copied; store -> regwrite=0.
REQ-025 Minimum memory latency 2 cycles (accept edge N, ack at N+1, ms_o_ce after N+1).
REQ-026 WAIT counter counts cycles without ack; at TIMEOUT_CYCLES, next edge req=0, ms_o_ce=1, ms_o_regwrite=0, ms_o_bus_err=1, state IDLE.
REQ-027 Ack in the same cycle the counter hits TIMEOUT_CYCLES SHALL win (normal completion).
REQ-028 ms_i_ce in WAIT ignored; ack in IDLE ignored.
REQ-029 ms_o_ce, misalign, bus_err SHALL be single-cycle pulses per instruction.
REQ-030 Cycles with no completion drive ms_o_ce=0, ms_o_regwrite=0.

Reset
REQ-031 Reset SHALL force state IDLE, counter 0, and all outputs 0 (ms_o_stall=0).
REQ-032 Reset in WAIT SHALL drop req on that edge with no ms_o_ce pulse; a late ack is ignored.

Structure
REQ-033 Opcode values (LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011) and width macros SHALL live in the shared definitions header.
REQ-034 Load extraction/extension SHALL be sub-module load_align (combinational: rdata, addr[1:0], opcode -> data).

Verification
REQ-035 Pass-through: opcode RTYPE, alu_value=9, rd=3, regwrite=1 -> next cycle ms_o_ce=1, data=9, rd=3, regwrite=1, no req.
REQ-036 LB: alu_value=0x102, rdata=0x0080FF00, ack 1st WAIT cycle -> sel=0100, addr=0x100, data=0xFFFFFF80, ce 2 cycles after accept.
REQ-037 SH: addr=0x202, rt=0x0000BEEF, ack after 3 WAIT cycles -> we=1, sel=1100, wdata=0xBEEFBEEF, stall high 3 cycles, regwrite=0.
REQ-038 LW at addr=0x101 -> no req, ms_o_misalign=1 one cycle, regwrite=0.
REQ-039 LW, ack never -> req held 15 cycles, then ms_o_bus_err=1, ce=1, regwrite=0, stall=0.
REQ-040 Reset asserted in 2nd WAIT cycle, ack next cycle -> req=0 after reset edge, no ms_o_ce pulse.

Source files
------------

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: data/opcode widths, memory opcode
// encodings, FSM state type and the byte-lane / store-data helpers used by
// the top level. The width and opcode macros are defined once here so every
// file that imports this package sees identical values.

`ifndef MEMORY_STAGE_DEFS
`define MEMORY_STAGE_DEFS
`define DWIDTH        32
`define OPCODE_WIDTH  6
`define OP_LB         6'b100000
`define OP_LH         6'b100001
`define OP_LW         6'b100011
`define OP_LBU        6'b100100
`define OP_LHU        6'b100101
`define OP_SB         6'b101000
`define OP_SH         6'b101001
`define OP_SW         6'b101011
`endif

package memory_stage_pkg;

    localparam int DWIDTH       = `DWIDTH;
    localparam int OPCODE_WIDTH = `OPCODE_WIDTH;

    localparam logic [OPCODE_WIDTH-1:0] OP_LB  = `OP_LB;
    localparam logic [OPCODE_WIDTH-1:0] OP_LH  = `OP_LH;
    localparam logic [OPCODE_WIDTH-1:0] OP_LW  = `OP_LW;
    localparam logic [OPCODE_WIDTH-1:0] OP_LBU = `OP_LBU;
    localparam logic [OPCODE_WIDTH-1:0] OP_LHU = `OP_LHU;
    localparam logic [OPCODE_WIDTH-1:0] OP_SB  = `OP_SB;
    localparam logic [OPCODE_WIDTH-1:0] OP_SH  = `OP_SH;
    localparam logic [OPCODE_WIDTH-1:0] OP_SW  = `OP_SW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } ms_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic mem_size_t op_size(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input mem_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

    // Little-endian lanes: byte offset a selects lane a.
    function automatic logic [3:0] lane_sel(input mem_size_t sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across the word so whichever lanes are
    // enabled by sel carry the right bytes.
    function automatic logic [DWIDTH-1:0] store_data(input mem_size_t sz,
                                                     input logic [DWIDTH-1:0] rt);
        case (sz)
            SZ_BYTE: return {4{rt[7:0]}};
            SZ_HALF: return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// load_align: combinational extraction of load data from a bus word.
// Ports:
//   rdata  - raw 32-bit word returned by the bus
//   off    - byte offset addr[1:0] of the original access
//   opcode - load opcode (LB/LH/LBU/LHU sized, LW and others unmodified)
//   data   - aligned, sign- or zero-extended result

module load_align
    import memory_stage_pkg::*;
(
    input  logic [DWIDTH-1:0]       rdata,
    input  logic [1:0]              off,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [DWIDTH-1:0]       data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        case (off)
            2'd0:    byte_val = rdata[7:0];
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            default: byte_val = rdata[31:24];
        endcase
        // Halfwords only ever arrive aligned, so off[1] picks the half.
        half_val = off[1] ? rdata[31:16] : rdata[15:0];

        case (opcode)
            OP_LB:   data = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  data = {24'd0, byte_val};
            OP_LH:   data = {{16{half_val[15]}}, half_val};
            OP_LHU:  data = {16'd0, half_val};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage. Non-memory instructions pass through
// in one cycle; loads/stores issue a single bus request, wait for ack with a
// timeout, then emit one result pulse.
// Ports:
//   ms_clk, ms_rst            - clock, synchronous active-high reset
//   ms_i_*                    - instruction from execute (ce, alu value,
//                               store data, opcode, rd, regwrite)
//   ms_o_stall                - upstream hold while a bus access is pending
//   ms_o_mem_* / ms_i_mem_*   - word-aligned bus request and ack/rdata
//   ms_o_ce, ms_o_data, ms_o_rd_addr, ms_o_regwrite - writeback result pulse
//   ms_o_misalign, ms_o_bus_err                     - fault pulses
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no bus access; accepts a new instruction each cycle
// WAIT  | request on the bus, holding it stable until ack or timeout

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    ms_clk,
    input  logic                    ms_rst,
    input  logic                    ms_i_ce,
    input  logic [DWIDTH-1:0]       ms_i_alu_value,
    input  logic [DWIDTH-1:0]       ms_i_data_rt,
    input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [4:0]              ms_i_rd_addr,
    input  logic                    ms_i_regwrite,
    output logic                    ms_o_stall,
    output logic                    ms_o_mem_req,
    output logic                    ms_o_mem_we,
    output logic [DWIDTH-1:0]       ms_o_mem_addr,
    output logic [DWIDTH-1:0]       ms_o_mem_wdata,
    output logic [3:0]              ms_o_mem_sel,
    input  logic                    ms_i_mem_ack,
    input  logic [DWIDTH-1:0]       ms_i_mem_rdata,
    output logic                    ms_o_ce,
    output logic [DWIDTH-1:0]       ms_o_data,
    output logic [4:0]              ms_o_rd_addr,
    output logic                    ms_o_regwrite,
    output logic                    ms_o_misalign,
    output logic                    ms_o_bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    ms_state_t                state_r, state_nxt;
    logic [CW-1:0]            cnt_r, cnt_nxt;
    logic                     req_r, req_nxt;
    logic                     we_r, we_nxt;
    logic [DWIDTH-1:0]        addr_r, addr_nxt;
    logic [DWIDTH-1:0]        wdata_r, wdata_nxt;
    logic [3:0]               sel_r, sel_nxt;
    logic [1:0]               off_r, off_nxt;
    logic [OPCODE_WIDTH-1:0]  op_r, op_nxt;
    logic [4:0]               prd_r, prd_nxt;
    logic                     prw_r, prw_nxt;
    logic                     oce_r, oce_nxt;
    logic [DWIDTH-1:0]        odata_r, odata_nxt;
    logic [4:0]               ord_r, ord_nxt;
    logic                     orw_r, orw_nxt;
    logic                     mis_r, mis_nxt;
    logic                     berr_r, berr_nxt;

    logic [DWIDTH-1:0]        load_data;
    mem_size_t                in_size;
    logic [1:0]               in_off;

    assign in_size = op_size(ms_i_opcode);
    assign in_off  = ms_i_alu_value[1:0];

    load_align u_load_align (
        .rdata  (ms_i_mem_rdata),
        .off    (off_r),
        .opcode (op_r),
        .data   (load_data)
    );

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        req_nxt   = req_r;
        we_nxt    = we_r;
        addr_nxt  = addr_r;
        wdata_nxt = wdata_r;
        sel_nxt   = sel_r;
        off_nxt   = off_r;
        op_nxt    = op_r;
        prd_nxt   = prd_r;
        prw_nxt   = prw_r;
        oce_nxt   = 1'b0;
        odata_nxt = odata_r;
        ord_nxt   = ord_r;
        orw_nxt   = 1'b0;
        mis_nxt   = 1'b0;
        berr_nxt  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (ms_i_ce) begin
                    if (!is_mem_op(ms_i_opcode)) begin
                        oce_nxt   = 1'b1;
                        odata_nxt = ms_i_alu_value;
                        ord_nxt   = ms_i_rd_addr;
                        orw_nxt   = ms_i_regwrite;
                    end else if (!is_aligned(in_size, in_off)) begin
                        // Report the faulting address; never write back.
                        oce_nxt   = 1'b1;
                        mis_nxt   = 1'b1;
                        odata_nxt = ms_i_alu_value;
                        ord_nxt   = ms_i_rd_addr;
                    end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CW'(TIMEOUT_CYCLES - 1);
                        req_nxt   = 1'b1;
                        we_nxt    = is_store(ms_i_opcode);
                        addr_nxt  = {ms_i_alu_value[DWIDTH-1:2], 2'b00};
                        wdata_nxt = store_data(in_size, ms_i_data_rt);
                        sel_nxt   = lane_sel(in_size, in_off);
                        off_nxt   = in_off;
                        op_nxt    = ms_i_opcode;
                        prd_nxt   = ms_i_rd_addr;
                        prw_nxt   = ms_i_regwrite;
                    end
                end
            end
            ST_WAIT: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (ms_i_mem_ack) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    oce_nxt   = 1'b1;
                    ord_nxt   = prd_r;
                    if (!we_r) begin
                        odata_nxt = load_data;
                        orw_nxt   = prw_r;
                    end
                end else if (cnt_r == '0) begin
                    state_nxt = ST_IDLE;
                    req_nxt   = 1'b0;
                    we_nxt    = 1'b0;
                    oce_nxt   = 1'b1;
                    berr_nxt  = 1'b1;
                    ord_nxt   = prd_r;
                end else begin
                    cnt_nxt = cnt_r - CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ms_clk) begin
        if (ms_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            sel_r   <= '0;
            off_r   <= '0;
            op_r    <= '0;
            prd_r   <= '0;
            prw_r   <= 1'b0;
            oce_r   <= 1'b0;
            odata_r <= '0;
            ord_r   <= '0;
            orw_r   <= 1'b0;
            mis_r   <= 1'b0;
            berr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            cnt_r   <= cnt_nxt;
            req_r   <= req_nxt;
            we_r    <= we_nxt;
            addr_r  <= addr_nxt;
            wdata_r <= wdata_nxt;
            sel_r   <= sel_nxt;
            off_r   <= off_nxt;
            op_r    <= op_nxt;
            prd_r   <= prd_nxt;
            prw_r   <= prw_nxt;
            oce_r   <= oce_nxt;
            odata_r <= odata_nxt;
            ord_r   <= ord_nxt;
            orw_r   <= orw_nxt;
            mis_r   <= mis_nxt;
            berr_r  <= berr_nxt;
        end
    end

    assign ms_o_stall     = (state_r == ST_WAIT);
    assign ms_o_mem_req   = req_r;
    assign ms_o_mem_we    = we_r;
    assign ms_o_mem_addr  = addr_r;
    assign ms_o_mem_wdata = wdata_r;
    assign ms_o_mem_sel   = sel_r;
    assign ms_o_ce        = oce_r;
    assign ms_o_data      = odata_r;
    assign ms_o_rd_addr   = ord_r;
    assign ms_o_regwrite  = orw_r;
    assign ms_o_misalign  = mis_r;
    assign ms_o_bus_err   = berr_r;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic        ms_clk;
    logic        ms_rst;
    logic        ms_i_ce;
    logic [31:0] ms_i_alu_value;
    logic [31:0] ms_i_data_rt;
    logic [5:0]  ms_i_opcode;
    logic [4:0]  ms_i_rd_addr;
    logic        ms_i_regwrite;
    logic        ms_o_stall;
    logic        ms_o_mem_req;
    logic        ms_o_mem_we;
    logic [31:0] ms_o_mem_addr;
    logic [31:0] ms_o_mem_wdata;
    logic [3:0]  ms_o_mem_sel;
    logic        ms_i_mem_ack;
    logic [31:0] ms_i_mem_rdata;
    logic        ms_o_ce;
    logic [31:0] ms_o_data;
    logic [4:0]  ms_o_rd_addr;
    logic        ms_o_regwrite;
    logic        ms_o_misalign;
    logic        ms_o_bus_err;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LB    = 6'b100000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] LHU   = 6'b100101;
    localparam logic [5:0] SB    = 6'b101000;
    localparam logic [5:0] SH    = 6'b101001;

    int passed = 0;
    int total  = 0;

    memory_stage #(.TIMEOUT_CYCLES(15)) dut (
        .ms_clk         (ms_clk),
        .ms_rst         (ms_rst),
        .ms_i_ce        (ms_i_ce),
        .ms_i_alu_value (ms_i_alu_value),
        .ms_i_data_rt   (ms_i_data_rt),
        .ms_i_opcode    (ms_i_opcode),
        .ms_i_rd_addr   (ms_i_rd_addr),
        .ms_i_regwrite  (ms_i_regwrite),
        .ms_o_stall     (ms_o_stall),
        .ms_o_mem_req   (ms_o_mem_req),
        .ms_o_mem_we    (ms_o_mem_we),
        .ms_o_mem_addr  (ms_o_mem_addr),
        .ms_o_mem_wdata (ms_o_mem_wdata),
        .ms_o_mem_sel   (ms_o_mem_sel),
        .ms_i_mem_ack   (ms_i_mem_ack),
        .ms_i_mem_rdata (ms_i_mem_rdata),
        .ms_o_ce        (ms_o_ce),
        .ms_o_data      (ms_o_data),
        .ms_o_rd_addr   (ms_o_rd_addr),
        .ms_o_regwrite  (ms_o_regwrite),
        .ms_o_misalign  (ms_o_misalign),
        .ms_o_bus_err   (ms_o_bus_err)
    );

    initial ms_clk = 1'b0;
    always #5 ms_clk = ~ms_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge ms_clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] alu,
                         input logic [31:0] rt, input logic [4:0] rd, input logic rw);
        ms_i_ce        = 1'b1;
        ms_i_opcode    = op;
        ms_i_alu_value = alu;
        ms_i_data_rt   = rt;
        ms_i_rd_addr   = rd;
        ms_i_regwrite  = rw;
    endtask

    task automatic test_reset();
        ms_rst = 1'b1;
        tick();
        tick();
        total++; if (ms_o_ce !== 1'b0) $display("FAIL rst_ce: got %0b want 0", ms_o_ce); else passed++;
        total++; if (ms_o_mem_req !== 1'b0) $display("FAIL rst_req: got %0b want 0", ms_o_mem_req); else passed++;
        total++; if (ms_o_stall !== 1'b0) $display("FAIL rst_stall: got %0b want 0", ms_o_stall); else passed++;
        total++; if (ms_o_data !== 32'h0) $display("FAIL rst_data: got %h want 0", ms_o_data); else passed++;
        total++; if ({ms_o_misalign, ms_o_bus_err, ms_o_regwrite} !== 3'b000)
            $display("FAIL rst_flags: got %b want 000", {ms_o_misalign, ms_o_bus_err, ms_o_regwrite}); else passed++;
        ms_rst = 1'b0;
    endtask

    task automatic test_passthrough();
        issue(RTYPE, 32'd9, 32'd0, 5'd3, 1'b1);
        tick();
        ms_i_ce = 1'b0;
        total++; if (ms_o_ce !== 1'b1) $display("FAIL pt_ce: got %0b want 1", ms_o_ce); else passed++;
        total++; if (ms_o_data !== 32'd9) $display("FAIL pt_data: got %h want 9", ms_o_data); else passed++;
        total++; if (ms_o_rd_addr !== 5'd3) $display("FAIL pt_rd: got %0d want 3", ms_o_rd_addr); else passed++;
        total++; if (ms_o_regwrite !== 1'b1) $display("FAIL pt_rw: got %0b want 1", ms_o_regwrite); else passed++;
        total++; if (ms_o_mem_req !== 1'b0) $display("FAIL pt_req: got %0b want 0", ms_o_mem_req); else passed++;
        tick();
        total++; if ({ms_o_ce, ms_o_regwrite} !== 2'b00) $display("FAIL pt_pulse: got %b want 00", {ms_o_ce, ms_o_regwrite}); else passed++;
    endtask

    task automatic test_lb();
        issue(LB, 32'h102, 32'h0, 5'd5, 1'b1);
        tick();
        ms_i_ce = 1'b0;
        total++; if (ms_o_mem_req !== 1'b1) $display("FAIL lb_req: got %0b want 1", ms_o_mem_req); else passed++;
        total++; if (ms_o_mem_sel !== 4'b0100) $display("FAIL lb_sel: got %b want 0100", ms_o_mem_sel); else passed++;
        total++; if (ms_o_mem_addr !== 32'h100) $display("FAIL lb_addr: got %h want 00000100", ms_o_mem_addr); else passed++;
        total++; if (ms_o_mem_we !== 1'b0) $display("FAIL lb_we: got %0b want 0", ms_o_mem_we); else passed++;
        total++; if ({ms_o_stall, ms_o_ce} !== 2'b10) $display("FAIL lb_stall_ce: got %b want 10", {ms_o_stall, ms_o_ce}); else passed++;
        ms_i_mem_ack   = 1'b1;
        ms_i_mem_rdata = 32'h0080FF00;
        tick();
        ms_i_mem_ack = 1'b0;
        total++; if (ms_o_ce !== 1'b1) $display("FAIL lb_ce: got %0b want 1", ms_o_ce); else passed++;
        total++; if (ms_o_data !== 32'hFFFFFF80) $display("FAIL lb_data: got %h want ffffff80", ms_o_data); else passed++;
        total++; if ({ms_o_regwrite, ms_o_rd_addr} !== {1'b1, 5'd5}) $display("FAIL lb_wb: got %b want 100101", {ms_o_regwrite, ms_o_rd_addr}); else passed++;
        total++; if ({ms_o_mem_req, ms_o_stall} !== 2'b00) $display("FAIL lb_done: got %b want 00", {ms_o_mem_req, ms_o_stall}); else passed++;
    endtask

    task automatic test_sh();
        int stall_cycles;
        stall_cycles = 0;
        issue(SH, 32'h202, 32'h0000BEEF, 5'd7, 1'b1);
        tick();
        // Held instruction during WAIT must be ignored.
        issue(RTYPE, 32'h55, 32'h0, 5'd9, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            if (ms_o_stall) stall_cycles++;
            total++; if ({ms_o_mem_req, ms_o_mem_we, ms_o_mem_sel} !== 6'b111100)
                $display("FAIL sh_ctrl_c%0d: got %b want 111100", k, {ms_o_mem_req, ms_o_mem_we, ms_o_mem_sel}); else passed++;
            total++; if (ms_o_mem_wdata !== 32'hBEEFBEEF) $display("FAIL sh_wdata_c%0d: got %h want beefbeef", k, ms_o_mem_wdata); else passed++;
            total++; if (ms_o_mem_addr !== 32'h200) $display("FAIL sh_addr_c%0d: got %h want 00000200", k, ms_o_mem_addr); else passed++;
            total++; if (ms_o_ce !== 1'b0) $display("FAIL sh_noce_c%0d: got %0b want 0", k, ms_o_ce); else passed++;
            if (k == 2) ms_i_ce = 1'b0;
            if (k == 3) ms_i_mem_ack = 1'b1;
            tick();
        end
        ms_i_mem_ack = 1'b0;
        total++; if (stall_cycles != 3) $display("FAIL sh_stall_len: got %0d want 3", stall_cycles); else passed++;
        total++; if ({ms_o_ce, ms_o_regwrite, ms_o_stall, ms_o_mem_req} !== 4'b1000)
            $display("FAIL sh_done: got %b want 1000", {ms_o_ce, ms_o_regwrite, ms_o_stall, ms_o_mem_req}); else passed++;
    endtask

    task automatic test_misalign();
        issue(LW, 32'h101, 32'h0, 5'd4, 1'b1);
        tick();
        ms_i_ce = 1'b0;
        total++; if ({ms_o_ce, ms_o_misalign, ms_o_regwrite} !== 3'b110)
            $display("FAIL mis_flags: got %b want 110", {ms_o_ce, ms_o_misalign, ms_o_regwrite}); else passed++;
        total++; if ({ms_o_mem_req, ms_o_stall} !== 2'b00) $display("FAIL mis_noreq: got %b want 00", {ms_o_mem_req, ms_o_stall}); else passed++;
        // Stray ack while idle must not produce anything.
        ms_i_mem_ack = 1'b1;
        tick();
        ms_i_mem_ack = 1'b0;
        total++; if ({ms_o_ce, ms_o_misalign} !== 2'b00) $display("FAIL mis_pulse: got %b want 00", {ms_o_ce, ms_o_misalign}); else passed++;
        tick();
        total++; if ({ms_o_ce, ms_o_mem_req} !== 2'b00) $display("FAIL idle_ack: got %b want 00", {ms_o_ce, ms_o_mem_req}); else passed++;
    endtask

    task automatic test_timeout();
        int  req_cycles;
        bit  done;
        req_cycles = 0;
        done = 1'b0;
        issue(LW, 32'h300, 32'h0, 5'd6, 1'b1);
        tick();
        ms_i_ce = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (ms_o_ce) done = 1'b1;
            else begin
                if (ms_o_mem_req) req_cycles++;
                tick();
            end
        end
        total++; if (!done) $display("FAIL to_complete: got no ce within 40 cycles want ce"); else passed++;
        total++; if (req_cycles != 15) $display("FAIL to_req_len: got %0d want 15", req_cycles); else passed++;
        total++; if ({ms_o_bus_err, ms_o_regwrite, ms_o_stall, ms_o_mem_req} !== 4'b1000)
            $display("FAIL to_flags: got %b want 1000", {ms_o_bus_err, ms_o_regwrite, ms_o_stall, ms_o_mem_req}); else passed++;
        tick();
        total++; if ({ms_o_ce, ms_o_bus_err} !== 2'b00) $display("FAIL to_pulse: got %b want 00", {ms_o_ce, ms_o_bus_err}); else passed++;
    endtask

    task automatic test_ack_at_timeout();
        issue(LW, 32'h400, 32'h0, 5'd8, 1'b1);
        tick();
        ms_i_ce = 1'b0;
        repeat (14) tick();
        total++; if ({ms_o_mem_req, ms_o_ce} !== 2'b10) $display("FAIL at_c15: got %b want 10", {ms_o_mem_req, ms_o_ce}); else passed++;
        ms_i_mem_ack   = 1'b1;
        ms_i_mem_rdata = 32'h12345678;
        tick();
        ms_i_mem_ack = 1'b0;
        total++; if ({ms_o_ce, ms_o_bus_err, ms_o_regwrite} !== 3'b101)
            $display("FAIL at_flags: got %b want 101", {ms_o_ce, ms_o_bus_err, ms_o_regwrite}); else passed++;
        total++; if (ms_o_data !== 32'h12345678) $display("FAIL at_data: got %h want 12345678", ms_o_data); else passed++;
    endtask

    task automatic test_reset_in_wait();
        issue(LW, 32'h500, 32'h0, 5'd2, 1'b1);
        tick();
        ms_i_ce = 1'b0;
        tick();
        ms_rst = 1'b1;
        tick();
        ms_rst = 1'b0;
        total++; if ({ms_o_mem_req, ms_o_stall, ms_o_ce} !== 3'b000)
            $display("FAIL rw_drop: got %b want 000", {ms_o_mem_req, ms_o_stall, ms_o_ce}); else passed++;
        ms_i_mem_ack   = 1'b1;
        ms_i_mem_rdata = 32'hCAFEF00D;
        tick();
        ms_i_mem_ack = 1'b0;
        total++; if ({ms_o_mem_req, ms_o_ce, ms_o_regwrite} !== 3'b000)
            $display("FAIL rw_late_ack: got %b want 000", {ms_o_mem_req, ms_o_ce, ms_o_regwrite}); else passed++;
    endtask

    task automatic test_back_to_back();
        issue(SB, 32'h13, 32'h000000A5, 5'd1, 1'b1);
        tick();
        total++; if ({ms_o_mem_sel, ms_o_mem_we} !== 5'b10001) $display("FAIL bb_sb_sel: got %b want 10001", {ms_o_mem_sel, ms_o_mem_we}); else passed++;
        total++; if (ms_o_mem_wdata !== 32'hA5A5A5A5) $display("FAIL bb_sb_wdata: got %h want a5a5a5a5", ms_o_mem_wdata); else passed++;
        total++; if (ms_o_mem_addr !== 32'h10) $display("FAIL bb_sb_addr: got %h want 00000010", ms_o_mem_addr); else passed++;
        issue(LHU, 32'h22, 32'h0, 5'd12, 1'b1);
        ms_i_mem_ack = 1'b1;
        tick();
        ms_i_mem_ack = 1'b0;
        total++; if ({ms_o_ce, ms_o_regwrite, ms_o_mem_req} !== 3'b100)
            $display("FAIL bb_sb_done: got %b want 100", {ms_o_ce, ms_o_regwrite, ms_o_mem_req}); else passed++;
        tick();
        ms_i_ce = 1'b0;
        total++; if ({ms_o_mem_req, ms_o_mem_sel, ms_o_ce} !== 6'b111000)
            $display("FAIL bb_lhu_req: got %b want 111000", {ms_o_mem_req, ms_o_mem_sel, ms_o_ce}); else passed++;
        total++; if (ms_o_mem_addr !== 32'h20) $display("FAIL bb_lhu_addr: got %h want 00000020", ms_o_mem_addr); else passed++;
        ms_i_mem_ack   = 1'b1;
        ms_i_mem_rdata = 32'h80010000;
        tick();
        ms_i_mem_ack = 1'b0;
        total++; if (ms_o_data !== 32'h00008001) $display("FAIL bb_lhu_data: got %h want 00008001", ms_o_data); else passed++;
        total++; if ({ms_o_ce, ms_o_regwrite, ms_o_rd_addr} !== {2'b11, 5'd12})
            $display("FAIL bb_lhu_wb: got %b want 1101100", {ms_o_ce, ms_o_regwrite, ms_o_rd_addr}); else passed++;
    endtask

    initial begin
        ms_rst         = 1'b1;
        ms_i_ce        = 1'b0;
        ms_i_alu_value = '0;
        ms_i_data_rt   = '0;
        ms_i_opcode    = '0;
        ms_i_rd_addr   = '0;
        ms_i_regwrite  = 1'b0;
        ms_i_mem_ack   = 1'b0;
        ms_i_mem_rdata = '0;

        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_misalign();
        test_timeout();
        test_ack_at_timeout();
        test_reset_in_wait();
        test_back_to_back();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
